if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction fetch stage and owner of the IF/ID pipeline register. It is the producer side of the IF/ID interface that the decode stage consumes.
- Issues one outstanding request at a time to instruction memory over a valid/ready request and rvalid response handshake.
- Honours the decode-stage hazard stall (stall_en) and branch/jump redirects.
- Drives if_id_IR, if_id_PC and if_id_valid_inst into decode.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INST, 32'h0000_0013, encoding (addi x0,x0,0) driven on if_id_IR when no valid instruction is present

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall_en  input  1  decode hazard stall; IF/ID register holds its contents while high
take_branch  input  1  redirect request from execute; takes priority over stall_en
branch_target  input  32  redirect PC; bits [1:0] ignored (forced 0)
imem_req  output  1  request valid
imem_addr  output  32  request word address (bits [1:0] = 0)
imem_ready  input  1  memory accepts the request this cycle
imem_rvalid  input  1  response valid (at least 1 cycle after accept)
imem_rdata  input  32  response instruction
if_id_IR  output  32  instruction to decode
if_id_PC  output  32  PC of if_id_IR
if_id_NPC  output  32  if_id_PC + 4
if_id_valid_inst  output  1  if_id_IR is a real instruction

Behaviour:
Reset (asynchronous):
- pc_reg=RESET_PC; state=FETCH; kill=0; hold buffer empty.
- if_id_IR=NOP_INST, if_id_PC=0, if_id_NPC=4, if_id_valid_inst=0.
- imem_req=0 while rst is high.

FSM states: FETCH, WAIT, HOLD.

FETCH:
- Drive imem_req=1 and imem_addr=pc_reg.
- imem_ready=1 -> go to WAIT.
- take_branch without accept -> pc_reg<=target; stay in FETCH. The address may change while the request is unaccepted.
- take_branch in the same cycle as accept -> request is issued to the old PC; set kill=1; pc_reg<=target; go to WAIT.

WAIT:
- imem_req=0.
- On imem_rvalid, drop the response when kill=1 or take_branch=1. Clear kill, apply the redirect if present, go to FETCH.
- Otherwise, if stall_en=0: load IF/ID with IR=rdata, PC=pc_reg, NPC=pc_reg+4, valid=1; pc_reg<=pc_reg+4; go to FETCH.
- Otherwise (stall_en=1): capture rdata and pc_reg into the hold buffer; go to HOLD.

HOLD:
- imem_req=0.
- take_branch -> discard the buffer, pc_reg<=target, go to FETCH.
- stall_en=0 -> move the buffer into IF/ID with valid=1; pc_reg<=pc_reg+4; go to FETCH.

IF/ID register update rules:
- stall_en=1 and take_branch=0: hold all fields.
- take_branch=1: flush to IR=NOP_INST, valid=0 next cycle, regardless of stall_en.
- stall_en=0 with no instruction delivered that cycle: insert a bubble (IR=NOP_INST, valid=0). PC and NPC keep their last values.

Arithmetic and boundaries:
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Throughput is at most one instruction per 2 cycles with single-cycle memory.
- An imem_rvalid in FETCH state is a protocol error. It is ignored, and an assertion flags it.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds output ports perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on each valid IF/ID load.
  - perf_stall_cnt increments on each cycle with stall_en=1 and if_id_valid_inst=1.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package if_pkg: fetch_state_t enum (FETCH, WAIT, HOLD), NOP_INST_DEFAULT constant, PC_STEP=4.
- One sub-module, fetch_hold_buf: a one-entry IR+PC buffer with load/unload/flush inputs and a full flag.

Test Plan:
1. Reset, RESET_PC=0, 1-cycle memory returning 0x00A00093 at addr 0 -> imem_addr=0; if_id_IR=0x00A00093, PC=0, valid=1 two cycles after rst falls; next imem_addr=4.
2. stall_en=1 held 3 cycles while rvalid arrives with 0x00100113 -> IF/ID unchanged and state=HOLD; after stall_en=0, IF/ID gets 0x00100113 with valid=1.
3. take_branch=1, target=0x40, asserted in the same cycle as imem_ready -> the response for the old PC is dropped, next imem_addr=0x40, if_id_valid_inst=0 for the intervening cycles.
4. take_branch and stall_en both high with IF/ID valid -> next cycle if_id_IR=0x00000013, valid=0.
5. pc_reg=0xFFFFFFFC, fetch completes -> next imem_addr=0x00000000; branch_target=0x43 -> imem_addr=0x40.
6. With IF_PERF_CNT_EN defined: 4 fetches and 2 stalled valid cycles -> perf_fetch_cnt=4, perf_stall_cnt=2; rst mid-run -> both counters 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional IF_PERF_CNT_EN macro adds perf counters in if_fetch_stage.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer parking a fetched IR+PC while decode is stalled.
// flush and unload both empty it; flush wins over load.
module fetch_hold_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] in_ir,
  input  logic [31:0] in_pc,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      ir   <= NOP_INST_DEFAULT;
      pc   <= '0;
    end else if (flush || unload) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      ir   <= in_ir;
      pc   <= in_pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: one outstanding imem request, owns the IF/ID register.
// Define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_stall_cnt ports.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_en,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_reg, pc_nxt;
  logic         kill, kill_nxt;
  logic [31:0]  tgt;
  logic         deliver;
  logic [31:0]  dl_ir, dl_pc;
  logic         buf_load, buf_unload, buf_flush;
  logic         buf_full;
  logic [31:0]  buf_ir, buf_pc;
  logic         unused_bits;

  assign tgt         = {branch_target[31:2], 2'b00};
  assign unused_bits = ^branch_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc_reg <= RESET_PC;
      kill   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_reg <= pc_nxt;
      kill   <= kill_nxt;
    end
  end

  // kill marks the outstanding request as belonging to a stale path
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_reg;
    kill_nxt  = kill;
    unique case (state)
      FETCH: begin
        if (take_branch) pc_nxt = tgt;
        if (imem_ready) begin
          state_nxt = WAIT;
          kill_nxt  = take_branch;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          kill_nxt = 1'b0;
          if (kill || take_branch || !stall_en)
            state_nxt = FETCH;
          else
            state_nxt = HOLD;
          if (take_branch)
            pc_nxt = tgt;
          else if (!kill && !stall_en)
            pc_nxt = pc_reg + PC_STEP;
        end else if (take_branch) begin
          kill_nxt = 1'b1;
          pc_nxt   = tgt;
        end
      end
      HOLD: begin
        if (take_branch) begin
          pc_nxt    = tgt;
          state_nxt = FETCH;
        end else if (!stall_en) begin
          pc_nxt    = pc_reg + PC_STEP;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req   = (state == FETCH) && !rst;
    imem_addr  = pc_reg;
    deliver    = 1'b0;
    dl_ir      = buf_ir;
    dl_pc      = buf_pc;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    buf_flush  = 1'b0;
    unique case (state)
      WAIT: begin
        if (imem_rvalid && !kill && !take_branch) begin
          if (!stall_en) begin
            deliver = 1'b1;
            dl_ir   = imem_rdata;
            dl_pc   = pc_reg;
          end else begin
            buf_load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (take_branch) begin
          buf_flush = 1'b1;
        end else if (!stall_en && buf_full) begin
          deliver    = 1'b1;
          buf_unload = 1'b1;
        end
      end
      default: ;
    endcase
  end

  fetch_hold_buf u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (buf_load),
    .unload (buf_unload),
    .flush  (buf_flush),
    .in_ir  (imem_rdata),
    .in_pc  (pc_reg),
    .ir     (buf_ir),
    .pc     (buf_pc),
    .full   (buf_full)
  );

  // Redirect beats stall; an unstalled cycle without delivery is a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_IR         <= NOP_INST;
      if_id_PC         <= '0;
      if_id_NPC        <= PC_STEP;
      if_id_valid_inst <= 1'b0;
    end else if (take_branch) begin
      if_id_IR         <= NOP_INST;
      if_id_valid_inst <= 1'b0;
    end else if (!stall_en) begin
      if (deliver) begin
        if_id_IR         <= dl_ir;
        if_id_PC         <= dl_pc;
        if_id_NPC        <= dl_pc + PC_STEP;
        if_id_valid_inst <= 1'b1;
      end else begin
        if_id_IR         <= NOP_INST;
        if_id_valid_inst <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (deliver)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_en && if_id_valid_inst)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  a_no_rvalid_in_fetch: assert property (
    @(posedge clk) disable iff (rst)
    !(state == FETCH && imem_rvalid));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table plus random
// traffic against a transaction-level reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_en = 1'b0;
  logic        take_branch = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_IR, if_id_PC, if_id_NPC;
  logic        if_id_valid_inst;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC (32'h0),
    .NOP_INST (NOP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_en         (stall_en),
    .take_branch      (take_branch),
    .branch_target    (branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_NPC        (if_id_NPC),
    .if_id_valid_inst (if_id_valid_inst)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        vld;
  } vec_t;

  vec_t vt[18];

  // reference model state
  logic [31:0] m_pc, m_paddr, m_hir, m_hpc;
  logic        m_pend, m_pkill, m_held;
  logic [31:0] m_ir, m_ipc;
  logic        m_valid;
  logic [31:0] m_fcnt, m_scnt;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  task automatic model_reset();
    m_pc = 32'h0; m_paddr = '0;
    m_hir = '0; m_hpc = '0;
    m_pend = 0; m_pkill = 0; m_held = 0;
    m_ir = NOP; m_ipc = '0; m_valid = 0;
    m_fcnt = '0; m_scnt = '0;
    mem_busy = 0; mem_cnt = 0; mem_addr = '0;
  endtask

  task automatic model_step(input logic st, input logic br,
                            input logic [31:0] tg,
                            input logic rdy, input logic rv);
    logic [31:0] t;
    logic        dlv;
    logic [31:0] d_ir, d_pc;
    t = {tg[31:2], 2'b00};
    dlv = 0; d_ir = '0; d_pc = '0;
    if (!m_pend && !m_held) begin
      if (rdy) begin
        m_pend = 1; m_paddr = m_pc; m_pkill = br;
      end
      if (br) m_pc = t;
    end else if (m_pend) begin
      if (rv) begin
        m_pend = 0;
        if (m_pkill || br) begin
          if (br) m_pc = t;
        end else if (!st) begin
          dlv = 1; d_ir = memw(m_paddr); d_pc = m_paddr;
          m_pc = m_paddr + 32'd4;
        end else begin
          m_held = 1; m_hir = memw(m_paddr); m_hpc = m_paddr;
        end
      end else if (br) begin
        m_pkill = 1; m_pc = t;
      end
    end else begin
      if (br) begin
        m_held = 0; m_pc = t;
      end else if (!st) begin
        dlv = 1; d_ir = m_hir; d_pc = m_hpc;
        m_pc = m_hpc + 32'd4; m_held = 0;
      end
    end
    if (st && m_valid) m_scnt = m_scnt + 32'd1;
    if (dlv) m_fcnt = m_fcnt + 32'd1;
    if (br) begin
      m_ir = NOP; m_valid = 0;
    end else if (!st) begin
      if (dlv) begin
        m_ir = d_ir; m_ipc = d_pc; m_valid = 1;
      end else begin
        m_ir = NOP; m_valid = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; stall_en = 0; take_branch = 0;
    imem_ready = 0; imem_rvalid = 0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_ir", if_id_IR, NOP);
    chk("rst_pc", if_id_PC, 0);
    chk("rst_npc", if_id_NPC, 4);
    chk("rst_vld", if_id_valid_inst, 0);
`ifdef IF_PERF_CNT_EN
    chk("rst_pfetch", perf_fetch_cnt, 0);
    chk("rst_pstall", perf_stall_cnt, 0);
`endif
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic rand_cycles(input int n);
    logic rv, rdy, st, br;
    logic [31:0] tg, rd;
    for (int c = 0; c < n; c++) begin
      if (mem_busy) mem_cnt--;
      rv  = mem_busy && (mem_cnt == 0);
      rd  = rv ? memw(mem_addr) : $urandom;
      st  = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        tg = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        tg = 32'($urandom_range(0, 255));
      stall_en = st; take_branch = br; branch_target = tg;
      imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
      #1;
      chk("r_req", imem_req, m_pend || m_held ? 0 : 1);
      if (!m_pend && !m_held) chk("r_addr", imem_addr, m_pc);
      chk("r_ir", if_id_IR, m_ir);
      chk("r_pc", if_id_PC, m_ipc);
      chk("r_npc", if_id_NPC, m_ipc + 32'd4);
      chk("r_vld", if_id_valid_inst, m_valid);
`ifdef IF_PERF_CNT_EN
      chk("r_pfetch", perf_fetch_cnt, m_fcnt);
      chk("r_pstall", perf_stall_cnt, m_scnt);
`endif
      if (rv) mem_busy = 0;
      if (imem_req && rdy) begin
        mem_busy = 1;
        mem_cnt  = $urandom_range(1, 3);
        mem_addr = imem_addr;
      end
      model_step(st, br, tg, rdy, rv);
      @(negedge clk);
    end
  endtask

  initial begin
    vt[0]  = '{0,0,32'h0,1,0,32'h0,         1,32'h0,NOP,32'h0,0};
    vt[1]  = '{0,0,32'h0,0,1,32'h00A00093,  0,32'h0,NOP,32'h0,0};
    vt[2]  = '{1,0,32'h0,1,0,32'h0,
               1,32'h4,32'h00A00093,32'h0,1};
    vt[3]  = '{1,0,32'h0,0,1,32'h00100113,
               0,32'h0,32'h00A00093,32'h0,1};
    vt[4]  = '{1,0,32'h0,0,0,32'h0,
               0,32'h0,32'h00A00093,32'h0,1};
    vt[5]  = '{1,0,32'h0,0,0,32'h0,
               0,32'h0,32'h00A00093,32'h0,1};
    vt[6]  = '{0,0,32'h0,0,0,32'h0,
               0,32'h0,32'h00A00093,32'h0,1};
    vt[7]  = '{0,1,32'h40,1,0,32'h0,
               1,32'h8,32'h00100113,32'h4,1};
    vt[8]  = '{0,0,32'h0,0,1,32'hDEADBEEF,  0,32'h0,NOP,32'h4,0};
    vt[9]  = '{0,0,32'h0,1,0,32'h0,         1,32'h40,NOP,32'h4,0};
    vt[10] = '{0,0,32'h0,0,1,32'h00000093,  0,32'h0,NOP,32'h4,0};
    vt[11] = '{1,1,32'h80,1,0,32'h0,
               1,32'h44,32'h00000093,32'h40,1};
    vt[12] = '{0,0,32'h0,0,1,32'h111,       0,32'h0,NOP,32'h40,0};
    vt[13] = '{0,1,32'hFFFFFFFF,0,0,32'h0,  1,32'h80,NOP,32'h40,0};
    vt[14] = '{0,0,32'h0,1,0,32'h0,
               1,32'hFFFFFFFC,NOP,32'h40,0};
    vt[15] = '{0,0,32'h0,0,1,32'h00200193,  0,32'h0,NOP,32'h40,0};
    vt[16] = '{0,1,32'h43,0,0,32'h0,
               1,32'h0,32'h00200193,32'hFFFFFFFC,1};
    vt[17] = '{0,0,32'h0,0,0,32'h0,
               1,32'h40,NOP,32'hFFFFFFFC,0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      stall_en      = vt[i].stall;
      take_branch   = vt[i].br;
      branch_target = vt[i].tgt;
      imem_ready    = vt[i].rdy;
      imem_rvalid   = vt[i].rv;
      imem_rdata    = vt[i].rd;
      #1;
      chk($sformatf("v%0d_req", i), imem_req, vt[i].req);
      if (vt[i].req)
        chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
      chk($sformatf("v%0d_ir", i), if_id_IR, vt[i].ir);
      chk($sformatf("v%0d_pc", i), if_id_PC, vt[i].pc);
      chk($sformatf("v%0d_npc", i), if_id_NPC, vt[i].pc + 32'd4);
      chk($sformatf("v%0d_vld", i), if_id_valid_inst, vt[i].vld);
      @(negedge clk);
    end

    do_reset();
    rand_cycles(1500);
    do_reset();
    rand_cycles(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
